dual_port_ram1: RTL and testbench
=================================

DUAL_PORT_RAM1 -- requirements
Module: dual_port_ram1

Interface
REQ-001 Parameter DEPTH_A, default 512, SHALL set the number of 8-bit words on write port A.
REQ-002 Parameter WIDTH_A, default 8, SHALL set the write data width.
REQ-003 Parameter WIDTH_B, default 16, SHALL set the read data width, which is 2*WIDTH_A.
REQ-004 The block SHALL use one clock, and its reset SHALL be synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 wea  input  1  write enable for port A.
REQ-008 addra  input  9  byte address for port A.
REQ-009 dia  input  8  write data for port A.
REQ-010 addrb  input  8  halfword address for port B.
REQ-011 dob  output  16  registered read data for port B.

Function
REQ-012 Storage SHALL be 512 x 8 bits, viewed by port B as 256 x 16 bits.
REQ-013 On a rising edge with rst_n=1 and wea=1, the block SHALL write mem[addra] <= dia.
REQ-014 When wea=0, the edge SHALL leave memory unchanged.
REQ-015 Port B SHALL read every cycle: dob <= {mem[2*addrb+1], mem[2*addrb]}, with the even byte on dob[7:0] (little-endian).
REQ-016 Read latency SHALL be exactly 1 clk: dob reflects the addrb sampled at the previous rising edge.
REQ-017 On a same-edge collision (write to byte 2*addrb or 2*addrb+1), dob SHALL return the old contents (read-first); new data appears on the next read.
REQ-018 Addresses SHALL be used in full, with no wrap or masking beyond the port widths; every addra 0..511 and addrb 0..255 is valid.
REQ-019 Memory contents after power-up SHALL be undefined (X in simulation); no initialisation file is loaded.
REQ-020 dob SHALL hold its value between edges and change only on a rising clk edge.

Reset
REQ-021 While rst_n=0 at a rising edge, dob SHALL be 16'h0000.
REQ-022 Writes SHALL be suppressed while rst_n=0.
REQ-023 Reset SHALL NOT clear memory contents; data written before reset is readable after reset deasserts.
REQ-024 On the first edge with rst_n=1, normal read behaviour SHALL resume with 1-cycle latency.
REQ-025 Reset asserted mid-operation SHALL take effect on the next rising edge, with no partial write.

Structure
REQ-026 A shared package SHALL hold the constants ADDR_A_W=9, ADDR_B_W=8, WIDTH_A=8 and WIDTH_B=16.
REQ-027 One sub-module, ram_bank (256 x 8 simple dual-port, single clock), SHALL be instantiated twice: the even bank holds addra[0]=0 and the odd bank holds addra[0]=1.
REQ-028 The write enable to each bank SHALL be wea & rst_n & (addra[0] == bank index), with addra[8:1] as the bank address.
REQ-029 Each bank SHALL read at addrb, and the dob register SHALL concatenate {odd, even}.
REQ-030 The RAM SHALL be inferable as block RAM, with no asynchronous read path.

Verification
REQ-031 Reset hold: rst_n=0 for 3 cycles with wea=1 and dia=8'hFF at addra 0 -> dob=16'h0000; after release, mem[0] is unchanged.
REQ-032 Basic pack: write 8'h21@0, 8'h43@1, 8'h65@2, 8'h87@3, then addrb=0 -> dob=16'h4321 one cycle later; addrb=1 -> dob=16'h8765.
REQ-033 Latency: switch addrb from 0 to 1 at edge N -> dob=16'h4321 until edge N+1, then 16'h8765.
REQ-034 Collision: with addrb=1 (holding 16'h8765), write 8'hAA@2 on edge N -> dob=16'h8765 after edge N and 16'h87AA after edge N+1.
REQ-035 Boundary: write 8'h5A@510 and 8'hC3@511, addrb=255 -> dob=16'hC35A; addrb=0 is unaffected.
REQ-036 Retention: write data, pulse reset, read back -> pre-reset data is returned.

Source files
------------

// File: rtl/dual_port_ram1_pkg.sv
// Shared constants for the 512 x 8 write / 256 x 16 read dual-port RAM.
package dual_port_ram1_pkg;

    localparam int DEPTH_A  = 512;
    localparam int ADDR_A_W = 9;
    localparam int ADDR_B_W = 8;
    localparam int WIDTH_A  = 8;
    localparam int WIDTH_B  = 16;
    localparam int BANK_DEPTH = DEPTH_A / 2;

endpackage

// File: rtl/dual_port_ram1_if.sv
// Byte-write / halfword-read bus of dual_port_ram1.
interface dual_port_ram1_if;
    import dual_port_ram1_pkg::*;

    logic                wea;
    logic [ADDR_A_W-1:0] addra;
    logic [WIDTH_A-1:0]  dia;
    logic [ADDR_B_W-1:0] addrb;
    logic [WIDTH_B-1:0]  dob;

    modport master (
        output wea,
        output addra,
        output dia,
        output addrb,
        input  dob
    );

    modport slave (
        input  wea,
        input  addra,
        input  dia,
        input  addrb,
        output dob
    );

endinterface

// File: rtl/dual_port_ram1_ram_bank.sv
// Single-clock simple dual-port byte bank, read-first, registered read with
// a synchronous output clear so it maps onto a block RAM output register.
module ram_bank
    import dual_port_ram1_pkg::*;
#(
    parameter int DEPTH = BANK_DEPTH,
    parameter int WIDTH = WIDTH_A,
    parameter int AW    = ADDR_B_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Memory array has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dual_port_ram1.sv
// 512 x 8 write port, 256 x 16 little-endian read port, built from an even
// and an odd byte bank selected by addra[0].
module dual_port_ram1
    import dual_port_ram1_pkg::*;
#(
    parameter int DEPTH_A = dual_port_ram1_pkg::DEPTH_A,
    parameter int WIDTH_A = dual_port_ram1_pkg::WIDTH_A,
    parameter int WIDTH_B = dual_port_ram1_pkg::WIDTH_B
) (
    input  logic               clk,
    input  logic               rst_n,
    dual_port_ram1_if.slave    bus
);

    logic               we_even;
    logic               we_odd;
    logic [WIDTH_A-1:0] rd_even;
    logic [WIDTH_A-1:0] rd_odd;
    logic [WIDTH_B-1:0] dob_w;

    // Reset gating keeps a write issued during reset from landing in memory.
    assign we_even = bus.wea & rst_n & (bus.addra[0] == 1'b0);
    assign we_odd  = bus.wea & rst_n & (bus.addra[0] == 1'b1);

    ram_bank #(
        .DEPTH (DEPTH_A / 2),
        .WIDTH (WIDTH_A),
        .AW    (ADDR_B_W)
    ) u_even (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_even),
        .waddr (bus.addra[ADDR_A_W-1:1]),
        .wdata (bus.dia),
        .raddr (bus.addrb),
        .rdata (rd_even)
    );

    ram_bank #(
        .DEPTH (DEPTH_A / 2),
        .WIDTH (WIDTH_A),
        .AW    (ADDR_B_W)
    ) u_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_odd),
        .waddr (bus.addra[ADDR_A_W-1:1]),
        .wdata (bus.dia),
        .raddr (bus.addrb),
        .rdata (rd_odd)
    );

    assign dob_w   = {rd_odd, rd_even};
    assign bus.dob = dob_w;

endmodule

// File: tb/tb_dual_port_ram1.sv
// Self-checking bench for dual_port_ram1: byte-level reference model feeds a
// scoreboard queue, plus literal checks at the directed scenario points.
module tb_dual_port_ram1;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [7:0]  model [0:511];
    logic [15:0] expq [$];

    dual_port_ram1_if bus ();

    dual_port_ram1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag);
        logic [15:0] e;
        if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s scoreboard empty, dob=%h", tag, bus.dob);
        end else begin
            e = expq.pop_front();
            if (!$isunknown(e)) begin
                vectors++;
                assert (bus.dob === e) else begin
                    miscompares++;
                    $error("[TB] FAIL %s dob=%h expected=%h", tag, bus.dob, e);
                end
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [15:0] e);
        vectors++;
        assert (bus.dob === e) else begin
            miscompares++;
            $error("[TB] FAIL %s dob=%h expected=%h", tag, bus.dob, e);
        end
    endtask

    // One clock: drive at negedge, predict read-first result, update model, check after edge.
    task automatic applyStimulus(input logic rn, input logic we, input logic [8:0] aa,
                                 input logic [7:0] d, input logic [7:0] ab, input string tag);
        logic [15:0] e;
        @(negedge clk);
        rst_n     = rn;
        bus.wea   = we;
        bus.addra = aa;
        bus.dia   = d;
        bus.addrb = ab;
        if (!rn) e = 16'h0000;
        else     e = {model[{ab, 1'b1}], model[{ab, 1'b0}]};
        expq.push_back(e);
        if (rn && we) model[aa] = d;
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.wea     = 1'b0;
        bus.addra   = '0;
        bus.dia     = '0;
        bus.addrb   = '0;

        applyStimulus(1'b0, 1'b0, 9'd0, 8'h00, 8'd0, "reset0");
        applyStimulus(1'b0, 1'b0, 9'd0, 8'h00, 8'd0, "reset1");
        checkValue("reset_dob", 16'h0000);

        applyStimulus(1'b1, 1'b1, 9'd0, 8'h21, 8'd0, "wr0");
        applyStimulus(1'b1, 1'b1, 9'd1, 8'h43, 8'd0, "wr1");
        applyStimulus(1'b1, 1'b1, 9'd2, 8'h65, 8'd0, "wr2");
        applyStimulus(1'b1, 1'b1, 9'd3, 8'h87, 8'd0, "wr3");
        applyStimulus(1'b1, 1'b0, 9'd0, 8'h00, 8'd0, "pack0");
        checkValue("pack0_lit", 16'h4321);

        @(negedge clk);
        bus.addrb = 8'd1;
        #1;
        checkValue("latency_hold", 16'h4321);
        applyStimulus(1'b1, 1'b0, 9'd0, 8'h00, 8'd1, "pack1");
        checkValue("pack1_lit", 16'h8765);

        applyStimulus(1'b1, 1'b1, 9'd2, 8'hAA, 8'd1, "collide");
        checkValue("collide_old", 16'h8765);
        applyStimulus(1'b1, 1'b0, 9'd0, 8'h00, 8'd1, "collide_next");
        checkValue("collide_new", 16'h87AA);

        applyStimulus(1'b1, 1'b1, 9'd510, 8'h5A, 8'd255, "wr510");
        applyStimulus(1'b1, 1'b1, 9'd511, 8'hC3, 8'd255, "wr511");
        applyStimulus(1'b1, 1'b0, 9'd0, 8'h00, 8'd255, "top");
        checkValue("top_lit", 16'hC35A);
        applyStimulus(1'b1, 1'b0, 9'd0, 8'h00, 8'd0, "bottom");
        checkValue("bottom_lit", 16'h4321);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 9'd0, 8'hFF, 8'd0, "reset_hold");
            checkValue("reset_hold_lit", 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 9'd0, 8'h00, 8'd0, "retain0");
        checkValue("retain0_lit", 16'h4321);
        applyStimulus(1'b1, 1'b0, 9'd0, 8'h00, 8'd1, "retain1");
        checkValue("retain1_lit", 16'h87AA);

        for (int i = 0; i < 60; i++) begin
            logic [8:0] ra;
            ra = 9'($urandom_range(0, 7));
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), ra, 8'($urandom),
                          8'($urandom_range(0, 3)), "random");
        end
        applyStimulus(1'b1, 1'b0, 9'd0, 8'h00, 8'd255, "top_after");
        checkValue("top_after_lit", 16'hC35A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
